perf_dump_ctrl: RTL

- Sequences the readout of the per-instruction-class event counters into data memory so software can read a consistent performance snapshot.
- On a dump request, it latches all counter values in one cycle. It then writes them one word at a time through a req/ack memory write port and flags completion.
- Sits between the instruction counter bank and the data-memory write arbiter of the processor.

---
 rtl/perf_pkg.sv | 36 +++
 rtl/perf_snapshot_regs.sv | 28 ++
 rtl/perf_dump_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter dump controller.
package perf_pkg;

   typedef enum logic [1:0] {IDLE, SNAP, WRITE, DONE} state_t;

   localparam int unsigned DEF_NUM_CNT   = 18;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0400;
   localparam logic [31:0] DEF_ADDR_STEP = 32'd4;

   localparam int unsigned CNT_ADD  = 0;
   localparam int unsigned CNT_SUB  = 1;
   localparam int unsigned CNT_AND  = 2;
   localparam int unsigned CNT_OR   = 3;
   localparam int unsigned CNT_XOR  = 4;
   localparam int unsigned CNT_NOR  = 5;
   localparam int unsigned CNT_SLT  = 6;
   localparam int unsigned CNT_SLL  = 7;
   localparam int unsigned CNT_SRL  = 8;
   localparam int unsigned CNT_SRA  = 9;
   localparam int unsigned CNT_ADDI = 10;
   localparam int unsigned CNT_ANDI = 11;
   localparam int unsigned CNT_ORI  = 12;
   localparam int unsigned CNT_LW   = 13;
   localparam int unsigned CNT_SW   = 14;
   localparam int unsigned CNT_BEQ  = 15;
   localparam int unsigned CNT_BNE  = 16;
   localparam int unsigned CNT_J    = 17;

   // Byte address of counter idx; arithmetic wraps modulo 2^32.
   function automatic logic [31:0] cnt_addr(input logic [31:0] base,
                                            input logic [31:0] step,
                                            input logic [31:0] idx);
      return base + idx * step;
   endfunction

endpackage

// File: rtl/perf_snapshot_regs.sv
// Snapshot storage for all counters: one-cycle parallel load, indexed read.
module perf_snapshot_regs
   import perf_pkg::*;
#(
   parameter int unsigned NUM_CNT = DEF_NUM_CNT,
   parameter int unsigned IDX_W   = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [NUM_CNT*32-1:0]  cnt_in,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [31:0]            rd_data
);

   logic [31:0] snap_q [NUM_CNT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= cnt_in[32*i +: 32];
      end
   end

   assign rd_data = (32'(rd_idx) < NUM_CNT) ? snap_q[rd_idx] : '0;

endmodule

// File: rtl/perf_dump_ctrl.sv
// Dumps a consistent snapshot of the instruction-class counters to data memory.
// Optional PERF_DUMP_CLEAR_EN adds cnt_clr, pulsed with done after a full dump.
module perf_dump_ctrl
   import perf_pkg::*;
#(
   parameter int unsigned NUM_CNT   = DEF_NUM_CNT,
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] ADDR_STEP = DEF_ADDR_STEP
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_CNT*32-1:0] cnt_in,
   output logic                  mem_req,
   input  logic                  mem_ack,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic [4:0]            words_written
`ifdef PERF_DUMP_CLEAR_EN
  ,output logic                  cnt_clr
`endif
);

   localparam int unsigned IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [4:0]       words_q;
   logic [4:0]       words_d;
   logic             req_q;
   logic             busy_q;
   logic             done_q;
   logic             clr_q;
   logic [31:0]      snap_data;

   assign idx_d   = idx_q + IDX_ONE;
   assign words_d = words_q + 5'd1;

   perf_snapshot_regs #(
      .NUM_CNT (NUM_CNT),
      .IDX_W   (IDX_W)
   ) u_snap (
      .clk     (clk),
      .reset   (reset),
      .load    (state_q == SNAP),
      .cnt_in  (cnt_in),
      .rd_idx  (idx_q),
      .rd_data (snap_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         words_q <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         clr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SNAP;
                  idx_q   <= '0;
                  words_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SNAP: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= WRITE;
                  req_q   <= 1'b1;
               end
            end
            WRITE: begin
               // An ack coinciding with abort is still counted.
               if (mem_ack) words_q <= words_d;
               if (abort) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (mem_ack) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= DONE;
                     req_q   <= 1'b0;
                     done_q  <= 1'b1;
                     clr_q   <= 1'b1;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Address and data are pure functions of registered state, so they hold until acked.
   assign mem_req       = req_q;
   assign mem_addr      = req_q ? cnt_addr(BASE_ADDR, ADDR_STEP, 32'(idx_q)) : '0;
   assign mem_wdata     = req_q ? snap_data : '0;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = words_q;

`ifdef PERF_DUMP_CLEAR_EN
   assign cnt_clr = clr_q;
`else
   logic unused_clr;
   assign unused_clr = clr_q;
`endif

endmodule
